// File: rtl/qei_sampler.sv
// ---------------------------------------------------------------------------
// qei_sampler
// Periodic sampling scheduler for a bank of QEI position counters. Every
// PERIOD clocks all channel positions are captured in the same cycle, then
// per-channel velocity (position delta since the previous sample) is computed
// one channel per cycle with a single shared subtractor. Latched positions and
// velocities are served to a host through a req/ack read port.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset
//   enable        sampling enable; low holds the timer at 0 and re-arms "first"
//   pos_in        live positions, channel k at [k*WIDTH +: WIDTH]
//   rd_req        host read request, held high until rd_ack
//   rd_sel        channel index to read
//   rd_kind       0 = latched position, 1 = velocity
//   rd_ack        one-cycle read acknowledge
//   rd_data       read data, valid while rd_ack = 1, holds otherwise
//   sample_valid  one-cycle pulse when a sample set is complete
//   sample_count  number of completed samples, wraps
//   overrun       sticky: a tick arrived while a sequence was still running
// ---------------------------------------------------------------------------
module qei_sampler #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PERIOD   = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] pos_in,
    input  logic                      rd_req,
    input  logic [3:0]                rd_sel,
    input  logic                      rd_kind,
    output logic                      rd_ack,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      sample_valid,
    output logic [15:0]               sample_count,
    output logic                      overrun
);

    localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned SW = 5;

    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(CHANNELS - 1);
    localparam logic [SW-1:0] SEL_LIMIT  = SW'(CHANNELS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SNAP = 2'd1,
        S_DIFF = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [TW-1:0]     r_timer;
    logic              w_tick;
    logic              r_first;
    logic [IW-1:0]     r_idx;

    logic [WIDTH-1:0]  r_snap [CHANNELS];
    logic [WIDTH-1:0]  r_prev [CHANNELS];
    logic [WIDTH-1:0]  r_vel  [CHANNELS];
    logic [WIDTH-1:0]  w_delta;

    logic              w_idle;
    logic              w_snap_en;
    logic              w_diff_en;
    logic              w_diff_last;
    logic              w_done;

    logic              w_grant;
    logic              w_sel_ok;
    logic [IW-1:0]     w_sel_idx;
    logic [WIDTH-1:0]  w_rd_value;

    logic              r_rd_ack;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_sample_valid;
    logic [15:0]       r_sample_count;
    logic              r_overrun;

    // Sample timer: free-runs 0..PERIOD-1 while enabled, parked at 0 otherwise.
    assign w_tick = enable && (r_timer == TIMER_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= '0;
        end else if (!enable || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_next_state = S_SNAP;
            S_SNAP:  w_next_state = S_DIFF;
            S_DIFF:  if (r_idx == IDX_LAST) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM decoded controls.
    always_comb begin
        w_idle      = 1'b0;
        w_snap_en   = 1'b0;
        w_diff_en   = 1'b0;
        w_diff_last = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: w_idle = 1'b1;
            S_SNAP: w_snap_en = 1'b1;
            S_DIFF: begin
                w_diff_en   = 1'b1;
                w_diff_last = (r_idx == IDX_LAST);
            end
            S_DONE: w_done = 1'b1;
            default: w_idle = 1'b0;
        endcase
    end

    // Channel cursor for the shared subtractor.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_snap_en) begin
            r_idx <= '0;
        end else if (w_diff_en) begin
            r_idx <= r_idx + IW'(1);
        end
    end

    // Modulo delta: a counter wrap still yields the small signed step.
    assign w_delta = r_first ? '0 : (r_snap[r_idx] - r_prev[r_idx]);

    // Coherent capture of every channel, then one velocity update per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                r_snap[k] <= '0;
                r_prev[k] <= '0;
                r_vel[k]  <= '0;
            end
        end else if (w_snap_en) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                r_snap[k] <= pos_in[k*WIDTH +: WIDTH];
            end
        end else if (w_diff_en) begin
            r_vel[r_idx]  <= w_delta;
            r_prev[r_idx] <= r_snap[r_idx];
        end
    end

    // "first" suppresses the delta for the first sample after reset or a
    // disable; a disable during a running sequence keeps it armed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_first <= 1'b1;
        end else if (!enable) begin
            r_first <= 1'b1;
        end else if (w_done) begin
            r_first <= 1'b0;
        end
    end

    // Reads only in IDLE so vel is never seen half-updated; tick wins, and
    // the pending ack blocks a back-to-back grant.
    assign w_grant   = w_idle && !w_tick && rd_req && !r_rd_ack;
    assign w_sel_ok  = ({1'b0, rd_sel} < SEL_LIMIT);
    assign w_sel_idx = rd_sel[IW-1:0];

    always_comb begin
        w_rd_value = '0;
        if (w_sel_ok) begin
            w_rd_value = rd_kind ? r_vel[w_sel_idx] : r_snap[w_sel_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack <= w_grant;
            if (w_grant) begin
                r_rd_data <= w_rd_value;
            end
        end
    end

    // Status: valid/count are raised on entry to DONE so they coincide with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sample_valid <= 1'b0;
            r_sample_count <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_sample_valid <= w_diff_last;
            if (w_diff_last) begin
                r_sample_count <= r_sample_count + 16'd1;
            end
            if (w_tick && !w_idle) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign rd_ack       = r_rd_ack;
    assign rd_data      = r_rd_data;
    assign sample_valid = r_sample_valid;
    assign sample_count = r_sample_count;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_qei_sampler.sv
// ---------------------------------------------------------------------------
// tb_qei_sampler
// Directed scoreboard bench for qei_sampler (CHANNELS=4, WIDTH=32, PERIOD=10).
// Cycle numbering: cycle 0 is the last cycle in which reset is sampled high,
// so the timer reads 0 in cycle 1, ticks in cycle 10, and DONE is cycle 16.
// ---------------------------------------------------------------------------
module tb_qei_sampler;

    localparam int CH  = 4;
    localparam int W   = 32;
    localparam int PER = 10;

    logic            clock;
    logic            reset;
    logic            enable;
    logic [CH*W-1:0] pos_in;
    logic            rd_req;
    logic [3:0]      rd_sel;
    logic            rd_kind;
    logic            rd_ack;
    logic [W-1:0]    rd_data;
    logic            sample_valid;
    logic [15:0]     sample_count;
    logic            overrun;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [31:0] rd_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          sv_seen  = 0;
    int          cyc      = 0;
    logic        rst_q;

    qei_sampler #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .PERIOD   (PER)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pos_in       (pos_in),
        .rd_req       (rd_req),
        .rd_sel       (rd_sel),
        .rd_kind      (rd_kind),
        .rd_ack       (rd_ack),
        .rd_data      (rd_data),
        .sample_valid (sample_valid),
        .sample_count (sample_count),
        .overrun      (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reset as the DUT saw it, and cycle number in the numbering above.
    always @(posedge clock) begin
        rst_q <= reset;
        cyc   <= reset ? 1 : cyc + 1;
    end

    function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    // Monitor: pops expected read data on each ack, counts samples
    // independently, and drains directed checks queued by the stimulus.
    always @(negedge clock) begin
        if (rst_q !== 1'b0) begin
            sv_seen = 0;
        end else begin
            if (sample_valid) begin
                sv_seen++;
                check("sample_count", 32'(sample_count), 32'(sv_seen));
                check("overrun_at_sample", 32'(overrun), 32'd0);
            end
            if (rd_ack) begin
                if (rd_q.size() == 0) begin
                    check("rd_ack_without_request", 32'(rd_ack), 32'd0);
                end else begin
                    check("rd_data", rd_data, rd_q.pop_front());
                end
            end
        end
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            check(c.name, c.got, c.exp);
        end
    end

    task automatic push_chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_t c;
        c.name = nm;
        c.got  = got;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic set_pos(input int k, input logic [31:0] v);
        pos_in[k*W +: W] = v;
    endtask

    // Waits (bounded) for the next sample_valid; returns its cycle number.
    task automatic wait_sample(output int at_cyc);
        int n;
        n = 0;
        @(negedge clock);
        while (!sample_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (!sample_valid) push_chk("sample_timeout", 32'(sample_valid), 32'd1);
        at_cyc = cyc;
    endtask

    // Issues one read, queues its expected data, waits (bounded) for the ack.
    task automatic do_read(input logic [3:0] sel, input logic kind, input logic [31:0] exp,
                           output int lat);
        rd_q.push_back(exp);
        rd_req  = 1'b1;
        rd_sel  = sel;
        rd_kind = kind;
        lat     = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rd_ack && lat < 60);
        if (!rd_ack) push_chk("ack_timeout", 32'(rd_ack), 32'd1);
        rd_req = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int lat;
        int sv0;

        reset   = 1'b1;
        enable  = 1'b1;
        rd_req  = 1'b0;
        rd_sel  = 4'd0;
        rd_kind = 1'b0;
        pos_in  = '0;
        set_pos(0, 32'd10);
        set_pos(1, 32'd20);
        set_pos(2, 32'd30);
        set_pos(3, 32'd40);
        repeat (3) @(negedge clock);
        push_chk("rst_rd_ack", 32'(rd_ack), 32'd0);
        push_chk("rst_rd_data", rd_data, 32'd0);
        push_chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        push_chk("rst_sample_count", 32'(sample_count), 32'd0);
        push_chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;

        // Sample 1 (cycle 16): first sample, vel forced to 0.
        wait_sample(c);
        push_chk("first_sample_cycle", 32'(c), 32'd16);
        do_read(4'd1, 1'b1, 32'd0, lat);
        do_read(4'd0, 1'b0, 32'd10, lat);
        @(negedge clock);
        push_chk("rd_data_hold", rd_data, 32'd10);

        // Samples 2 and 3: remaining positions, still zero velocity.
        wait_sample(c);
        do_read(4'd1, 1'b0, 32'd20, lat);
        do_read(4'd2, 1'b0, 32'd30, lat);
        wait_sample(c);
        do_read(4'd3, 1'b0, 32'd40, lat);
        do_read(4'd2, 1'b1, 32'd0, lat);
        set_pos(0, 32'd15);
        set_pos(1, 32'd17);

        // Sample 4: positive and negative deltas.
        wait_sample(c);
        do_read(4'd0, 1'b1, 32'd5, lat);
        do_read(4'd1, 1'b1, 32'hFFFF_FFFD, lat);
        set_pos(2, 32'hFFFF_FFFE);

        // Samples 5 and 6: counter wrap FFFFFFFE -> 1 gives +3.
        wait_sample(c);
        do_read(4'd2, 1'b0, 32'hFFFF_FFFE, lat);
        do_read(4'd0, 1'b1, 32'd0, lat);
        set_pos(2, 32'd1);
        wait_sample(c);
        do_read(4'd2, 1'b1, 32'd3, lat);
        do_read(4'd2, 1'b0, 32'd1, lat);
        set_pos(3, 32'd100);

        // Sample 7 (vel3 = 60), then a request raised on the tick cycle must
        // wait for sample 8 and return its vel3 = 130 - 100.
        wait_sample(c);
        repeat (4) @(negedge clock);
        set_pos(3, 32'd130);
        do_read(4'd3, 1'b1, 32'd30, lat);
        push_chk("tick_read_latency", 32'(lat), 32'd8);
        do_read(4'd7, 1'b0, 32'd0, lat);
        push_chk("sel7_read_latency", 32'(lat), 32'd2);

        // Drop enable mid-DIFF: the running sequence still completes once.
        wait_sample(c);
        repeat (7) @(negedge clock);
        enable = 1'b0;
        set_pos(0, 32'd1015);
        sv0 = sv_seen;
        repeat (20) @(negedge clock);
        push_chk("samples_while_disabled", 32'(sv_seen - sv0), 32'd1);
        enable = 1'b1;
        wait_sample(c);
        do_read(4'd0, 1'b1, 32'd0, lat);
        do_read(4'd0, 1'b0, 32'd1015, lat);
        push_chk("overrun_after_reenable", 32'(overrun), 32'd0);

        // Reset mid-DIFF: everything cleared, timer restarts from 0.
        wait_sample(c);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        push_chk("mid_rst_rd_ack", 32'(rd_ack), 32'd0);
        push_chk("mid_rst_rd_data", rd_data, 32'd0);
        push_chk("mid_rst_sample_valid", 32'(sample_valid), 32'd0);
        push_chk("mid_rst_sample_count", 32'(sample_count), 32'd0);
        push_chk("mid_rst_overrun", 32'(overrun), 32'd0);
        for (int k = 0; k < CH; k++) begin
            do_read(4'(k), 1'b1, 32'd0, lat);
        end
        do_read(4'd0, 1'b0, 32'd0, lat);
        wait_sample(c);
        push_chk("post_reset_sample_cycle", 32'(c), 32'd16);

        push_chk("pending_reads", 32'(rd_q.size()), 32'd0);
        push_chk("overrun_final", 32'(overrun), 32'd0);
        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
